// File: rtl/lmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lmul_sequencer
// Description : Iterative WIDTH x WIDTH -> 2*WIDTH long multiplier (UMULL /
//               SMULL). It captures the operands on start, takes magnitudes,
//               runs one shift-add step per cycle for WIDTH cycles, negates the
//               product when the signed result must be negative, then writes
//               the low half and the high half on consecutive cycles.
//
// Ports       : clk     - core clock, rising edge
//               reset   - synchronous, active-high
//               start   - one-cycle request, sampled only in IDLE
//               Signed  - 1 = SMULL, 0 = UMULL (captured with start)
//               SrcA    - multiplicand (captured with start)
//               SrcB    - multiplier   (captured with start)
//               busy    - high from LOAD through WRHI
//               WrEn    - register-file write request (WRLO, WRHI)
//               WrSel   - 0 = RdLo, 1 = RdHi
//               WrData  - product half being written, 0 otherwise
//               done    - one-cycle pulse in WRHI
//               NFlag   - bit 2*WIDTH-1 of the final product
//               ZFlag   - final product is zero
//
// Revision    : 1.0 - initial release
// ============================================================================
module lmul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             WrEn,
    output logic             WrSel,
    output logic [WIDTH-1:0] WrData,
    output logic             done,
    output logic             NFlag,
    output logic             ZFlag
);

    // Iteration counter: wide enough to hold WIDTH-1 without wrapping.
    localparam int c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_MUL   = 3'd2;
    localparam logic [2:0] c_FIXUP = 3'd3;
    localparam logic [2:0] c_WRLO  = 3'd4;
    localparam logic [2:0] c_WRHI  = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;

    logic [WIDTH-1:0]   r_a;        // operand A, becomes |A| in LOAD
    logic [WIDTH-1:0]   r_b;        // operand B as captured
    logic               r_signed;
    logic               r_neg;
    logic [WIDTH-1:0]   r_mult;     // multiplier shift register
    logic [2*WIDTH-1:0] r_acc;
    logic [c_CNT_W-1:0] r_count;
    logic               r_nflag;
    logic               r_zflag;

    logic               w_accept;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_acc_fix;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_LOAD;
            c_LOAD:  w_next_state = c_MUL;
            c_MUL:   if (r_count == c_CNT_LAST) w_next_state = c_FIXUP;
            c_FIXUP: w_next_state = c_WRLO;
            c_WRLO:  w_next_state = c_WRHI;
            c_WRHI:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    assign w_accept = (r_state == c_IDLE) && start;

    // Magnitudes are unsigned, so |0x80..0| stays 0x80..0 and is still correct.
    assign w_mag_a = (r_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_mag_b = (r_signed && r_b[WIDTH-1]) ? -r_b : r_b;

    assign w_addend  = {{WIDTH{1'b0}}, r_a} << r_count;
    assign w_acc_fix = r_neg ? -r_acc : r_acc;

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_neg    <= 1'b0;
            r_mult   <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_nflag  <= 1'b0;
            r_zflag  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_a      <= SrcA;
                        r_b      <= SrcB;
                        r_signed <= Signed;
                    end
                end
                c_LOAD: begin
                    r_a     <= w_mag_a;
                    r_mult  <= w_mag_b;
                    r_neg   <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_acc   <= '0;
                    r_count <= '0;
                end
                c_MUL: begin
                    if (r_mult[0]) begin
                        r_acc <= r_acc + w_addend;
                    end
                    r_mult <= r_mult >> 1;
                    // Hold at the last value instead of wrapping on exit.
                    if (r_count != c_CNT_LAST) begin
                        r_count <= r_count + c_CNT_ONE;
                    end
                end
                c_FIXUP: begin
                    r_acc   <= w_acc_fix;
                    r_nflag <= w_acc_fix[2*WIDTH-1];
                    r_zflag <= (w_acc_fix == '0);
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded from the state register and registered datapath only
    // ------------------------------------------------------------------------
    always_comb begin
        busy   = (r_state != c_IDLE);
        WrEn   = (r_state == c_WRLO) || (r_state == c_WRHI);
        WrSel  = (r_state == c_WRHI);
        done   = (r_state == c_WRHI);
        WrData = '0;
        if (r_state == c_WRLO) begin
            WrData = r_acc[WIDTH-1:0];
        end else if (r_state == c_WRHI) begin
            WrData = r_acc[2*WIDTH-1:WIDTH];
        end
        NFlag  = r_nflag;
        ZFlag  = r_zflag;
    end

endmodule
`default_nettype wire

// File: tb/tb_lmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lmul_sequencer
// Description : Directed self-checking bench for lmul_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lmul_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        Signed;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        WrEn;
    logic        WrSel;
    logic [31:0] WrData;
    logic        done;
    logic        NFlag;
    logic        ZFlag;

    int n_cmp  = 0;
    int n_fail = 0;

    lmul_sequencer #(.WIDTH(32)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Signed (Signed),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .busy   (busy),
        .WrEn   (WrEn),
        .WrSel  (WrSel),
        .WrData (WrData),
        .done   (done),
        .NFlag  (NFlag),
        .ZFlag  (ZFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one multiply from a start pulse and checks the whole timeline.
    // With inj=1, extra start pulses are issued at T+5 and T+36.
    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] lo, input logic [31:0] hi,
                           input logic n, input logic z, input logic inj);
        int done_cyc = -1;
        int n_done   = 0;
        int n_wren   = 0;
        @(negedge clk);
        start = 1'b1; Signed = s; SrcA = a; SrcB = b;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (inj && (k == 5 || k == 36)) begin
                start = 1'b1; Signed = 1'b0; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (WrEn) n_wren++;
            if (k == 1)  chk({name, " busy@T+1"}, 64'(busy), 64'd1);
            if (k == 35) chk({name, " WRLO sel/data"}, {31'd0, WrEn, WrSel, WrData}, {31'd0, 1'b1, 1'b0, lo});
            if (k == 36) chk({name, " WRHI sel/data"}, {31'd0, WrEn, WrSel, WrData}, {31'd0, 1'b1, 1'b1, hi});
            if (k == 37) begin
                chk({name, " idle busy/data"}, {31'd0, busy, WrData}, 64'd0);
                chk({name, " N/Z"}, {62'd0, NFlag, ZFlag}, {62'd0, n, z});
            end
        end
        chk({name, " done cycle"}, 64'(done_cyc), 64'd36);
        chk({name, " done count / WrEn count"}, {32'(n_done), 32'(n_wren)}, {32'd1, 32'd2});
    endtask

    initial begin
        int n_wren_rst;
        reset = 1'b1; start = 1'b0; Signed = 1'b0; SrcA = '0; SrcB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset outputs", {25'd0, busy, WrEn, WrSel, done, NFlag, ZFlag, WrData},
            64'd0);

        run_mul("umax",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        run_mul("smixed",    32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_mul("umixed",    32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 32'hFFFF_FFFA, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        run_mul("smin*smin", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
        run_mul("m1*m1",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        run_mul("zero",      32'h0000_0000, 32'h1234_5678, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        run_mul("busystart", 32'h0000_0007, 32'h0000_0006, 1'b0, 32'h0000_002A, 32'h0000_0000, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of MUL: no write may escape, all outputs clear.
        n_wren_rst = 0;
        @(negedge clk);
        start = 1'b1; Signed = 1'b0; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (WrEn) n_wren_rst++;
            if (k == 10) reset = 1'b1;
            if (k == 11) begin
                reset = 1'b0;
                chk("mid-reset outputs", {25'd0, busy, WrEn, WrSel, done, NFlag, ZFlag, WrData},
                    64'd0);
            end
        end
        chk("mid-reset no write", 64'(n_wren_rst), 64'd0);

        run_mul("post-reset", 32'h1234_5678, 32'h0000_0010, 1'b1, 32'h2345_6780, 32'h0000_0001, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lmul_sequencer.md
# lmul_sequencer

Iterative 32x32→64 long-multiply unit for the multicycle core, used when the controller decodes a UMULL/SMULL (lmulFlag asserted). It captures two register operands, runs a fixed-latency shift-add sequence, applies the sign fix-up, then drives the single register-file write port for two consecutive cycles (RdLo, then RdHi). The main FSM stalls on `busy` and resumes on `done`. The block also produces N/Z flags over the 64-bit result.

## Interface
Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request from the controller; sampled only in IDLE
- Signed  in  1  1=SMULL (two's-complement), 0=UMULL; captured with start
- SrcA  in  WIDTH  multiplicand (Rm); captured with start
- SrcB  in  WIDTH  multiplier (Rs); captured with start
- busy  out  1  high from the cycle after start is accepted through the WRHI cycle
- WrEn  out  1  register-file write request; high in WRLO and WRHI
- WrSel  out  1  0=write RdLo, 1=write RdHi; valid only while WrEn=1
- WrData  out  WIDTH  low product half in WRLO, high half in WRHI; 0 otherwise
- done  out  1  one-cycle pulse in WRHI
- NFlag  out  1  bit 63 of the final product; held from FIXUP until the next accepted start
- ZFlag  out  1  1 if the 64-bit product is zero; same validity as NFlag

## Operation
- States: IDLE, LOAD, MUL, FIXUP, WRLO, WRHI.
- IDLE: if start=1, capture SrcA, SrcB, and Signed, then go to LOAD. Otherwise remain in IDLE.
- LOAD:
  - Compute magnitudes |A| and |B|. In unsigned mode, pass the operands through.
  - Store neg = Signed & (A[31] ^ B[31]).
  - Clear the 64-bit accumulator. Load the multiplier shift register with |B|. Set the count to 0.
  - Go to MUL.
- MUL:
  - Each cycle, if mult[0]=1, add (|A| << count) into the accumulator.
  - Shift mult right by 1 and increment count.
  - After count reaches WIDTH-1, i.e. after exactly WIDTH iterations, go to FIXUP.
  - Count is a 6-bit register with no wrap inside MUL.
- FIXUP:
  - If neg=1, replace the accumulator with its 64-bit two's-complement negation.
  - Register NFlag = acc[63] and ZFlag = (acc==0) from the fixed-up value.
  - Go to WRLO.
- WRLO: WrEn=1, WrSel=0, WrData=acc[31:0]. Go to WRHI.
- WRHI: WrEn=1, WrSel=1, WrData=acc[63:32], done=1. Go to IDLE.
- Arithmetic:
  - The accumulator is 64-bit unsigned and addition is modulo 2^64.
  - |0x80000000| = 0x80000000, held as unsigned 32-bit. Correct because the magnitude datapath is unsigned.
- Boundary conditions:
  - start while busy is ignored; no queueing.
  - start in the WRHI cycle is ignored. It is accepted only from the IDLE cycle onward.
  - Signed=0 forces neg=0 regardless of operand MSBs.
  - Zero operands still take the full latency; there is no early exit.
- Reset at any cycle, including mid-MUL:
  - Next state is IDLE.
  - busy, WrEn, WrSel, WrData, done, NFlag, and ZFlag are all 0.
  - Accumulator and count are cleared.
  - No partial write is issued.

## Timing
- Reset values: busy=0, WrEn=0, WrSel=0, WrData=0, done=0, NFlag=0, ZFlag=0, state=IDLE.
- Cycle timeline, with start=1 in IDLE at cycle T:
  - LOAD at T+1.
  - MUL at T+2 through T+33 (32 cycles).
  - FIXUP at T+34.
  - WRLO at T+35.
  - WRHI at T+36.
  - IDLE at T+37.
- Latency from start to done is 36 cycles. busy is high at T+1 through T+36.
- All outputs are registered or decoded from the state register only. No combinational path runs from start/SrcA/SrcB to any output.
- The earliest back-to-back start is at T+37, giving a throughput of one multiply per 37 cycles.
- The controller must hold Rd/Ra address selection stable from T+35 to T+36. The block does not latch register addresses.

## Test plan
- Unsigned max: SrcA=SrcB=0xFFFFFFFF, Signed=0.
  - WRLO WrData=0x00000001; WRHI WrData=0xFFFFFFFE.
  - N=1, Z=0; done exactly at T+36.
- Signed mixed: SrcA=0xFFFFFFFE (-2), SrcB=3, Signed=1.
  - Lo=0xFFFFFFFA, Hi=0xFFFFFFFF, N=1, Z=0.
  - Same operands with Signed=0: Lo=0xFFFFFFFA, Hi=0x00000002, N=0.
- Signed extremes:
  - 0x80000000 * 0x80000000, Signed=1: Hi=0x40000000, Lo=0, N=0.
  - -1 * -1: Lo=1, Hi=0.
- Zero: SrcA=0, SrcB=0x12345678.
  - Lo=Hi=0, Z=1, N=0.
  - Full 36-cycle latency still observed.
- Start while busy: pulse start at T+5 and T+36 with different operands.
  - Both pulses are ignored and the first result is unchanged.
  - Only one done pulse occurs; WrEn is high for exactly 2 cycles.
- Reset mid-operation: assert reset at T+10 for one cycle.
  - From T+11, busy=0 and all outputs are 0.
  - No WrEn pulse occurs.
  - A fresh start at T+12 yields a correct result at T+48.
